// File: rtl/lint_rr_arbiter.sv
// Round-robin arbiter: NUM_REQ valid/ready requesters share one registered
// output slot; a rotating priority pointer provides fairness.
module lint_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [IDX_W-1:0]          out_id,
  input  logic                      out_ready,
  output logic [7:0]                stall_cnt
);

  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]  out_id_q, out_id_d;
  logic [7:0]        stall_cnt_q, stall_cnt_d;

  logic             grant_found;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] cand_idx;
  int               cand;
  logic             slot_free;
  logic             accept;

  // Scan from rr_ptr upward, wrapping at NUM_REQ rather than at 2**IDX_W.
  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign slot_free = !out_valid_q || out_ready;
  assign accept    = grant_found && slot_free && !rst;
  assign req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;

    if (out_valid_q && !out_ready) begin
      stall_cnt_d = (stall_cnt_q == 8'hFF) ? stall_cnt_q : stall_cnt_q + 8'd1;
    end else begin
      stall_cnt_d = '0;
    end

    // A same-cycle acceptance overwrites the word being delivered.
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = req_data[int'(grant_idx)*DATA_W +: DATA_W];
      out_id_d    = grant_idx;
      rr_ptr_d    = (int'(grant_idx) == NUM_REQ-1) ? '0 : grant_idx + 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_lint_rr_arbiter.sv
// Bench for lint_rr_arbiter: directed stimulus, a per-cycle reference model
// comparison on the falling edge, and hand-computed literal expectations.
module tb_lint_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_id;
  logic          out_ready;
  logic [7:0]    stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  lint_rr_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the arbiter's observable state as plain integers.
  int        m_ptr   = 0;
  bit        m_ov    = 1'b0;
  logic [7:0] m_od   = '0;
  int        m_oid   = 0;
  int        m_stall = 0;

  function automatic int model_winner();
    for (int d = 0; d < N; d++) begin
      if (req_valid[2'((m_ptr + d) % N)]) return (m_ptr + d) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    r = '0;
    if (rst || (m_ov && !out_ready) || model_winner() < 0) return r;
    r[2'(model_winner())] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr   <= 0;
      m_ov    <= 1'b0;
      m_od    <= '0;
      m_oid   <= 0;
      m_stall <= 0;
    end else begin
      if (m_ov && !out_ready) m_stall <= (m_stall < 255) ? m_stall + 1 : 255;
      else                    m_stall <= 0;
      if (model_winner() >= 0 && (!m_ov || out_ready)) begin
        m_od  <= req_data[model_winner()*DW +: DW];
        m_oid <= model_winner();
        m_ov  <= 1'b1;
        m_ptr <= (model_winner() + 1) % N;
      end else if (m_ov && out_ready) begin
        m_ov <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("cmp_req_ready", 32'(req_ready), 32'(model_ready()));
    check("cmp_out_valid", 32'(out_valid), 32'(m_ov));
    check("cmp_out_data",  32'(out_data),  32'(m_od));
    check("cmp_out_id",    32'(out_id),    32'(m_oid));
    check("cmp_stall_cnt", 32'(stall_cnt), 32'(m_stall));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_stall",     32'(stall_cnt), 32'd0);
    check("rst_ready",     32'(req_ready), 32'd0);
    check("rst_out_id",    32'(out_id),    32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    rst = 1'b0;

    // Fair rotation from pointer 0
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("rot_ready", 32'(req_ready), 32'(1 << (k % 4)));
      tick();
      check("rot_valid", 32'(out_valid), 32'd1);
      check("rot_id",    32'(out_id),    32'(k % 4));
      check("rot_data",  32'(out_data),  32'(8'h10 + k % 4));
    end
    req_valid = '0;
    tick();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_hold_data", 32'(out_data), 32'h10);
    tick();

    // Single requester, pointer at 1
    req_data  = {8'h00, 8'hA5, 8'h00, 8'h00};
    req_valid = 4'b0100;
    #1;
    check("single_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    #1;
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data",  32'(out_data),  32'hA5);
    check("single_id",    32'(out_id),    32'd2);
    tick();
    tick();

    // Wrap from pointer 3
    req_data  = {8'h00, 8'h00, 8'hC1, 8'hC0};
    req_valid = 4'b0011;
    #1;
    check("wrap_ready0", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0010;
    #1;
    check("wrap_id0",    32'(out_id),    32'd0);
    check("wrap_data0",  32'(out_data),  32'hC0);
    check("wrap_ready1", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    #1;
    check("wrap_id1",   32'(out_id),   32'd1);
    check("wrap_data1", 32'(out_data), 32'hC1);
    repeat (3) tick();

    // Pointer held at 2 across idle cycles
    req_data  = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    req_valid = 4'b1111;
    #1;
    check("hold_ready", 32'(req_ready), 32'b0100);
    tick();
    check("hold_id", 32'(out_id), 32'd2);
    req_valid = 4'b1011;
    out_ready = 1'b0;

    // Backpressure for 300 cycles
    for (int k = 1; k <= 300; k++) begin
      tick();
      check("bp_ready", 32'(req_ready), 32'd0);
      check("bp_data",  32'(out_data),  32'hD2);
      if (k == 10)  check("bp_stall10",  32'(stall_cnt), 32'd10);
      if (k == 255) check("bp_stall255", 32'(stall_cnt), 32'd255);
    end
    check("bp_stall_sat", 32'(stall_cnt), 32'd255);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(req_ready), 32'b1000);
    tick();
    req_valid = 4'b0011;
    out_ready = 1'b0;
    #1;
    check("bp_stall_clear", 32'(stall_cnt), 32'd0);
    check("bp_next_id",     32'(out_id),    32'd3);
    check("bp_next_data",   32'(out_data),  32'hD3);
    repeat (40) tick();
    check("stall40", 32'(stall_cnt), 32'd40);

    // Reset mid-stall
    req_valid = 4'b1111;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_stall", 32'(stall_cnt), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    check("mid_rst_id",    32'(out_id),    32'd0);
    check("mid_rst_data",  32'(out_data),  32'd0);
    tick();
    check("in_rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    #1;
    check("post_rst_id",   32'(out_id),   32'd0);
    check("post_rst_data", 32'(out_data), 32'hD0);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
